// File: rtl/axis_stream_arbiter_if.sv
// ============================================================================
// axis_stream_arbiter_if
// NUM_SRC-wide AXI4-Stream source bundle plus the single shared master link.
// Rev 1.0
// ============================================================================
`default_nettype none

interface axis_stream_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 4,
  parameter int ID_WIDTH   = 4
);
  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_SRC*USER_WIDTH-1:0] s_axis_tuser;
  logic [NUM_SRC-1:0]            s_axis_tlast;
  logic [NUM_SRC-1:0]            s_axis_tvalid;
  logic [NUM_SRC-1:0]            s_axis_tready;

  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic [DATA_WIDTH/8-1:0]       m_axis_tstrb;
  logic [DATA_WIDTH/8-1:0]       m_axis_tkeep;
  logic                          m_axis_tlast;
  logic [USER_WIDTH-1:0]         m_axis_tuser;
  logic [ID_WIDTH-1:0]           m_axis_tid;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;

  // master: the arbiter, which drives the shared m_axis link
  modport master (
    input  s_axis_tdata, s_axis_tuser, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
           m_axis_tuser, m_axis_tid, m_axis_tvalid
  );

  // slave: the environment, which feeds the sources and sinks the link
  modport slave (
    output s_axis_tdata, s_axis_tuser, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
           m_axis_tuser, m_axis_tid, m_axis_tvalid
  );
endinterface

`default_nettype wire

// File: rtl/axis_stream_arbiter.sv
// ============================================================================
// axis_stream_arbiter
// Packet-level round-robin AXI4-Stream arbiter with a registered output stage.
// Optional per-source packet counters: define AXIS_ARB_STATS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module axis_stream_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 4,
  parameter int ID_WIDTH   = 4
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  axis_stream_arbiter_if.master            axis,
  output logic                             grant_active,
  output logic [$clog2(NUM_SRC)-1:0]       grant_idx,
  output logic [NUM_SRC*32-1:0]            pkt_cnt
);

  localparam int               IDX_W     = $clog2(NUM_SRC);
  localparam logic [IDX_W:0]   NUM_SRC_W = (IDX_W+1)'(NUM_SRC);
  localparam logic [0:0]       S_IDLE    = 1'b0;
  localparam logic [0:0]       S_LOCKED  = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_found;
  logic [IDX_W:0]        cand;
  logic [NUM_SRC-1:0]    src_ready;
  logic                  out_free;
  logic                  accept;
  logic                  beat_last;

  logic [DATA_WIDTH-1:0] out_data;
  logic [USER_WIDTH-1:0] out_user;
  logic [ID_WIDTH-1:0]   out_tid;
  logic                  out_last;
  logic                  out_valid;

  // Round-robin scan starting just after the last source that finished a packet
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (cand >= NUM_SRC_W) cand = cand - NUM_SRC_W;
      if (!sel_found && axis.s_axis_tvalid[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign out_free  = !out_valid || axis.m_axis_tready;
  assign accept    = grant_active && axis.s_axis_tvalid[grant_idx] && out_free;
  assign beat_last = axis.s_axis_tlast[grant_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= IDX_W'(NUM_SRC - 1);
      grant_idx  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && sel_found) grant_idx <= sel_idx;
      if (accept && beat_last) last_grant <= grant_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (sel_found) state_nxt = S_LOCKED;
      S_LOCKED: if (accept && beat_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant_active = (state == S_LOCKED);
    src_ready    = '0;
    if (state == S_LOCKED && out_free) src_ready[grant_idx] = 1'b1;
  end

  assign axis.s_axis_tready = src_ready;

  // Output stage: load on accept, drop valid once the sink takes the beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= '0;
      out_tid   <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= axis.s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      out_user  <= axis.s_axis_tuser[grant_idx*USER_WIDTH +: USER_WIDTH];
      out_tid   <= ID_WIDTH'(grant_idx);
      out_last  <= beat_last;
    end else if (axis.m_axis_tready) begin
      out_valid <= 1'b0;
    end
  end

  assign axis.m_axis_tdata  = out_data;
  assign axis.m_axis_tuser  = out_user;
  assign axis.m_axis_tid    = out_tid;
  assign axis.m_axis_tlast  = out_last;
  assign axis.m_axis_tvalid = out_valid;
  assign axis.m_axis_tstrb  = '1;
  assign axis.m_axis_tkeep  = '1;

`ifdef AXIS_ARB_STATS_EN
  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_pkt_cnt
      logic [31:0] cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (accept && beat_last && grant_idx == IDX_W'(i)) begin
          cnt <= cnt + 32'd1;
        end
      end
      assign pkt_cnt[i*32 +: 32] = cnt;
    end
  endgenerate
`else
  assign pkt_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_stream_arbiter.sv
// ============================================================================
// tb_axis_stream_arbiter
// Directed scoreboard bench for the packet round-robin stream arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axis_stream_arbiter;

  localparam int NS  = 4;
  localparam int DW  = 128;
  localparam int UW  = 4;
  localparam int IDW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
    int            gap;
  } beat_t;

  typedef struct {
    logic [DW-1:0]  data;
    logic [UW-1:0]  user;
    logic           last;
    logic [IDW-1:0] tid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_stream_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IDW)) ifc ();

  logic                grant_active;
  logic [1:0]          grant_idx;
  logic [NS*32-1:0]    pkt_cnt;

  axis_stream_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .axis         (ifc),
    .grant_active (grant_active),
    .grant_idx    (grant_idx),
    .pkt_cnt      (pkt_cnt)
  );

  beat_t srcq [NS][$];
  exp_t  expq [$];
  bit    armed [NS];
  int    waitc [NS];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit sb_en  = 1'b0;
  bit gap_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mk_data(input int s, input int p, input int b);
    return {4{8'(s), 8'(p), 8'(b), 8'hA5}};
  endfunction

  task automatic add_pkt(input int s, input int p, input int nb, input int gap_beat,
                         input int gap_len, input bit push_exp);
    beat_t bt;
    exp_t  e;
    for (int b = 0; b < nb; b++) begin
      bt.data = mk_data(s, p, b);
      bt.user = UW'(b ^ s);
      bt.last = (b == nb - 1);
      bt.gap  = (b == gap_beat) ? gap_len : 0;
      srcq[s].push_back(bt);
      if (push_exp) begin
        e.data = bt.data;
        e.user = bt.user;
        e.last = bt.last;
        e.tid  = IDW'(s);
        expq.push_back(e);
      end
    end
  endtask

  task automatic check(input string name, input logic [NS*32-1:0] act, input logic [NS*32-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_m_tvalid"}, NS*32'(ifc.m_axis_tvalid), '0);
    check({tag, "_m_tdata"},  NS*32'(ifc.m_axis_tdata), '0);
    check({tag, "_m_tuser"},  NS*32'(ifc.m_axis_tuser), '0);
    check({tag, "_m_tid"},    NS*32'(ifc.m_axis_tid), '0);
    check({tag, "_m_tlast"},  NS*32'(ifc.m_axis_tlast), '0);
    check({tag, "_s_tready"}, NS*32'(ifc.s_axis_tready), '0);
    check({tag, "_grant_active"}, NS*32'(grant_active), '0);
    check({tag, "_grant_idx"}, NS*32'(grant_idx), '0);
    check({tag, "_pkt_cnt"}, pkt_cnt, '0);
  endtask

  task automatic flush();
    for (int i = 0; i < NS; i++) begin
      srcq[i].delete();
      armed[i] = 1'b0;
      waitc[i] = 0;
    end
    expq.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
      busy = (expq.size() != 0) || ifc.m_axis_tvalid;
      for (int i = 0; i < NS; i++) if (srcq[i].size() != 0) busy = 1'b1;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d beats still expected after %0d cycles", name, expq.size(), budget);
    end
  endtask

  // Source drivers: advance a source queue after each accepted beat
  initial begin
    logic [NS-1:0] hs;
    ifc.s_axis_tvalid = '0;
    ifc.s_axis_tdata  = '0;
    ifc.s_axis_tuser  = '0;
    ifc.s_axis_tlast  = '0;
    forever begin
      @(negedge clk);
      hs = ifc.s_axis_tvalid & ifc.s_axis_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (hs[i] && srcq[i].size() != 0) begin
          void'(srcq[i].pop_front());
          armed[i] = 1'b0;
        end
        if (srcq[i].size() == 0) begin
          ifc.s_axis_tvalid[i] = 1'b0;
        end else begin
          if (!armed[i]) begin
            armed[i] = 1'b1;
            waitc[i] = srcq[i][0].gap;
          end
          if (waitc[i] > 0) begin
            waitc[i]--;
            ifc.s_axis_tvalid[i] = 1'b0;
          end else begin
            ifc.s_axis_tdata[i*DW +: DW] = srcq[i][0].data;
            ifc.s_axis_tuser[i*UW +: UW] = srcq[i][0].user;
            ifc.s_axis_tlast[i]          = srcq[i][0].last;
            ifc.s_axis_tvalid[i]         = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: scoreboard pops, stall stability, ready routing, packet gap
  initial begin
    exp_t          e;
    logic [NS-1:0] exp_rdy;
    bit            stall_prev;
    bit            prev_last;
    int            last_cyc;
    logic [DW-1:0] held_data;
    logic [IDW-1:0] held_tid;
    stall_prev = 1'b0;
    prev_last  = 1'b0;
    last_cyc   = 0;
    held_data  = '0;
    held_tid   = '0;
    forever begin
      @(negedge clk);
      if (rst || !sb_en) begin
        stall_prev = 1'b0;
        prev_last  = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (!(ifc.m_axis_tvalid && ifc.m_axis_tdata === held_data && ifc.m_axis_tid === held_tid)) begin
            errors++;
            $display("FAIL stall_hold: got valid=%0b tid=%0h data=%0h expected valid=1 tid=%0h data=%0h",
                     ifc.m_axis_tvalid, ifc.m_axis_tid, ifc.m_axis_tdata, held_tid, held_data);
          end
        end
        stall_prev = ifc.m_axis_tvalid && !ifc.m_axis_tready;
        held_data  = ifc.m_axis_tdata;
        held_tid   = ifc.m_axis_tid;

        exp_rdy = (grant_active && (!ifc.m_axis_tvalid || ifc.m_axis_tready)) ? (NS'(1) << grant_idx) : '0;
        checks++;
        if (ifc.s_axis_tready !== exp_rdy) begin
          errors++;
          $display("FAIL s_tready: got %b expected %b", ifc.s_axis_tready, exp_rdy);
        end

        if (ifc.m_axis_tvalid && ifc.m_axis_tready) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got tid=%0h data=%0h expected no beat", ifc.m_axis_tid, ifc.m_axis_tdata);
          end else begin
            e = expq.pop_front();
            if (ifc.m_axis_tdata !== e.data || ifc.m_axis_tuser !== e.user ||
                ifc.m_axis_tlast !== e.last || ifc.m_axis_tid !== e.tid) begin
              errors++;
              $display("FAIL beat: got tid=%0h last=%0b user=%0h data=%0h expected tid=%0h last=%0b user=%0h data=%0h",
                       ifc.m_axis_tid, ifc.m_axis_tlast, ifc.m_axis_tuser, ifc.m_axis_tdata,
                       e.tid, e.last, e.user, e.data);
            end
          end
          if (gap_chk && prev_last) begin
            checks++;
            if (cyc - last_cyc != 2) begin
              errors++;
              $display("FAIL pkt_gap: got %0d cycles between packets expected 2", cyc - last_cyc);
            end
          end
          prev_last = ifc.m_axis_tlast;
          if (ifc.m_axis_tlast) last_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int t0;
    int t1;
    logic [NS*32-1:0] exp_cnt;
    ifc.m_axis_tready = 1'b1;
    for (int i = 0; i < NS; i++) begin
      armed[i] = 1'b0;
      waitc[i] = 0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    check("tstrb_tkeep", NS*32'({ifc.m_axis_tstrb, ifc.m_axis_tkeep}), NS*32'({(DW/4){1'b1}}));

    // Abandon a packet in flight with an asynchronous reset
    @(posedge clk);
    #1 rst = 1'b0;
    add_pkt(1, 0, 6, -1, 0, 1'b0);
    t0 = 0;
    while (!ifc.m_axis_tvalid && t0 < 20) begin
      @(negedge clk);
      t0++;
    end
    check("pre_rst_stream", NS*32'(ifc.m_axis_tvalid), NS*32'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset("mid_rst");
    flush();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb_en = 1'b1;

    // Round robin: all sources offer two 3-beat packets
    gap_chk = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++)
        add_pkt(s, p, 3, -1, 0, 1'b1);
    wait_drain("round_robin", 200);
    gap_chk = 1'b0;

    // Backpressure on a 4-beat packet from source 2
    add_pkt(2, 10, 4, -1, 0, 1'b1);
    for (int n = 0; n < 16; n++) begin
      @(posedge clk);
      #1 ifc.m_axis_tready = ~ifc.m_axis_tready;
    end
    ifc.m_axis_tready = 1'b1;
    wait_drain("backpressure", 100);

    // Sparse: source 1 then lone source 3, measure request-to-valid latency
    add_pkt(1, 20, 1, -1, 0, 1'b1);
    wait_drain("sparse_src1", 50);
    repeat (3) @(posedge clk);
    add_pkt(3, 21, 1, -1, 0, 1'b1);
    t0 = -1;
    t1 = -1;
    for (int n = 0; n < 20 && t1 < 0; n++) begin
      @(negedge clk);
      if (t0 < 0 && ifc.s_axis_tvalid[3]) t0 = cyc;
      if (t0 >= 0 && t1 < 0 && ifc.m_axis_tvalid) t1 = cyc;
    end
    check("sparse_latency", NS*32'(t1 - t0), NS*32'(2));
    wait_drain("sparse_src3", 50);

    // Source 1 stalls 5 cycles mid-packet while source 0 waits
    add_pkt(1, 30, 4, 2, 5, 1'b1);
    t0 = 0;
    while (!(grant_active && grant_idx == 2'd1) && t0 < 20) begin
      @(negedge clk);
      t0++;
    end
    check("drop_grant_src1", NS*32'({grant_active, grant_idx}), NS*32'(3'b101));
    add_pkt(0, 31, 2, -1, 0, 1'b1);
    wait_drain("valid_drop", 100);

`ifdef AXIS_ARB_STATS_EN
    exp_cnt = {32'd3, 32'd3, 32'd4, 32'd3};
`else
    exp_cnt = '0;
`endif
    check("pkt_cnt", pkt_cnt, exp_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/axis_stream_arbiter.md
# axis_stream_arbiter

Packet-level round-robin arbiter that shares one AXI4-Stream master link between NUM_SRC streaming sources in the NPU data flow. Once a source is granted, the grant is held until that source's tlast beat is accepted, so packets are never interleaved. The output side is a registered single-entry stage. Each beat leaves with its source index stamped on tid, so downstream blocks can demultiplex.

## Interface
- NUM_SRC, 4: number of source ports; legal range 2..16.
- DATA_WIDTH, 128: tdata width in bits; must be a multiple of 8.
- USER_WIDTH, 4: tuser width in bits.
- ID_WIDTH, 4: m_axis_tid width; must satisfy ID_WIDTH >= $clog2(NUM_SRC).
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tuser  in  NUM_SRC*USER_WIDTH  source user sideband, packed the same way as tdata.
- s_axis_tlast  in  NUM_SRC  per-source end-of-packet flag.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tready  out  NUM_SRC  per-source ready; at most one bit is high in any cycle.
- m_axis_tdata  out  DATA_WIDTH  registered output data.
- m_axis_tstrb / m_axis_tkeep  out  DATA_WIDTH/8 each  constant all-ones.
- m_axis_tlast  out  1  registered end-of-packet flag.
- m_axis_tuser  out  USER_WIDTH  registered user sideband.
- m_axis_tid  out  ID_WIDTH  source index of the beat, zero-extended.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- grant_active  out  1  high while in state LOCKED.
- grant_idx  out  $clog2(NUM_SRC)  currently or most recently granted source.
- pkt_cnt  out  NUM_SRC*32  per-source packet counters; see Configuration.

## Operation
- FSM states: IDLE and LOCKED.
- IDLE:
  - If any s_axis_tvalid bit is high, select the first valid source scanning upward from last_grant+1, wrapping modulo NUM_SRC.
  - Register the selection into grant_idx and go to LOCKED.
  - No s_axis_tready is asserted while in IDLE.
- LOCKED:
  - out_free = !m_axis_tvalid || m_axis_tready.
  - s_axis_tready[grant_idx] = out_free; all other ready bits are 0.
  - Beat accept: s_axis_tvalid[g] && s_axis_tready[g] with g = grant_idx. On accept, load tdata, tuser, tlast and tid=g into the output register and set m_axis_tvalid=1.
  - If the accepted beat has tlast=1: set last_grant <= g and go to IDLE.
- Output register: with no accept this cycle and m_axis_tready=1, clear m_axis_tvalid. Otherwise hold all output fields.
- Valid deasserted mid-packet by the granted source: the grant is held indefinitely. Other sources stall; no timeout.
- Single-beat packets (tlast on the first beat) are legal: one beat, then back to IDLE.
- Fairness: a source that keeps requesting is served within NUM_SRC packets.

## Timing
- Reset values:
  - state=IDLE, last_grant=NUM_SRC-1 (source 0 has first priority), grant_idx=0, grant_active=0.
  - m_axis_tvalid=0, m_axis_tdata/tuser/tid/tlast=0, s_axis_tready=0, pkt_cnt=0.
- Reset asserted mid-packet: the in-flight packet is abandoned and the output beat is dropped. After release, arbitration restarts from source 0 priority.
- Latency:
  - Source valid in cycle 0 while IDLE → grant registered at edge 1 → first beat accepted in cycle 1 → m_axis_tvalid high in cycle 2.
  - Steady state inside a packet with m_axis_tready=1: one beat per cycle.
- Packet boundary: exactly one IDLE arbitration cycle between consecutive packets, so output throughput loses one cycle per packet.
- Simultaneous events: the tlast accept and a new request in the same cycle are handled by the IDLE cycle that follows; no same-cycle regrant.
- Downstream stall: if m_axis_tready=0 while m_axis_tvalid=1, the granted source's ready drops in the same cycle (combinational) and the output holds stable.

## Configuration
- AXIS_ARB_STATS_EN defined:
  - pkt_cnt[i*32 +: 32] increments by 1 on every accepted tlast beat from source i.
  - Counters wrap from 0xFFFF_FFFF to 0.
  - Cleared only by rst.
- Not defined: pkt_cnt is tied to 0 and no counter flops are built; all other behaviour is identical.

## Test plan
- Reset check: assert rst mid-stream → all outputs at their reset values. Release rst, raise all four valids → first packet comes from source 0 with m_axis_tid=0.
- Round-robin: all four sources offer 3-beat packets continuously → output tid sequence 0,1,2,3,0,…, with a one-cycle gap between packets and no interleaving.
- Backpressure: m_axis_tready toggles 1,0,1,0 during a 4-beat packet from source 2 → all 4 beats are delivered in order, data is stable while stalled, and s_axis_tready[2] tracks out_free.
- Sparse request: only source 3 valid, 1-beat packets, last_grant=1 → source 3 is granted and m_axis_tvalid goes high 2 cycles after s_axis_tvalid[3].
- Mid-packet valid drop: source 1 drops valid for 5 cycles mid-packet while source 0 requests → source 0 stays unserved until source 1's tlast is accepted.
- With AXIS_ARB_STATS_EN: 5 packets from source 0 and 2 from source 3 → pkt_cnt slot 0 = 5, slot 3 = 2, others 0. Preload slot 0 to 0xFFFF_FFFF, send 1 packet → slot 0 = 0.
